sd_spi_card_model: RTL and testbench
====================================

Name: sd_spi_card_model

Overview:
Parametrised SPI-mode SD card slave model for the verification environment. It supports a multi-block memory, the full init handshake (CMD0/CMD8/CMD55/ACMD41/CMD58), and single-block read (CMD17) and write (CMD24). Write data is received over SPI with a data token, CRC bytes, a data response and busy signalling. It sits on the DUT's SPI bus. The SPI pins are oversampled in the clk domain.

Parameters:
BLOCK_BYTES, 16, data bytes per block (power of 2, 4..512)
NUM_BLOCKS, 8, number of blocks in memory (1..256)
NCR_BYTES, 1, 0xFF bytes sent between command end and R1 (1..8)
INIT_POLLS, 2, ACMD41 count before the card leaves idle (1..15)
RD_DELAY_BYTES, 2, 0xFF bytes between R1 and the 0xFE read token
BUSY_BYTES, 3, 0x00 busy bytes after the write data response

Ports:
clk  in  1  system clock; sclk must be at least 4x slower
rst_n  in  1  asynchronous reset, active-low
cs_n  in  1  SPI chip select, active-low
sclk  in  1  SPI clock, mode 0
mosi  in  1  SPI data in
miso  out  1  SPI data out, driven 1 when not transmitting
card_idle  out  1  R1 idle bit (1 = not yet initialised)
cmd_strobe  out  1  one-clk pulse when a 6-byte command is accepted
cmd_index  out  6  index of the last accepted command
busy  out  1  high during write busy bytes

Behaviour:
- Reset values: miso=1, card_idle=1, cmd_strobe=0, cmd_index=0, busy=0, app_cmd=0, poll counter=0, FSM=CMD_RX. Memory is not reset. Its initial content is byte(b,i) = (b*BLOCK_BYTES+i) mod 256.
- Edges: rise = sclk & !sclk_q; fall = !sclk & sclk_q. Both are qualified by !cs_n.
- Sampling: mosi shifts in MSB-first on rise. miso updates on fall, MSB-first, from an 8-bit tx shift register.
- cs_n high: FSM returns to CMD_RX and miso=1 on the next clk. A partial write is discarded, because memory is only committed after CRC.
- CMD_RX: assemble bytes. A byte with [7:6]!=2'b01 is ignored while waiting for the first byte. After 6 bytes: cmd_strobe pulses, cmd_index updates, go to NCR and send NCR_BYTES x 0xFF, then R1.
- R1 value: bit0 = card_idle; bit2 = illegal; bit3 = CRC error; bit6 = parameter error.
- CMD0: card_idle<=1, poll counter cleared, R1=0x01.
- CMD8: R1, then 00 00 0X YY, where X = arg[11:8] and YY = arg[7:0].
- CMD55: R1. Sets app_cmd for the next command only.
- ACMD41 (app_cmd and index 41): poll counter increments. R1=0x01 until the count reaches INIT_POLLS. On that command card_idle<=0 and R1=0x00.
- CMD41 without a preceding CMD55 is illegal (R1 bit2).
- CMD58: R1, then OCR 0xC0FF8000 when card_idle=0, or 0x00FF8000 when card_idle=1.
- CMD17/CMD24 while card_idle=1: R1=0x05, no data phase.
- CMD17/CMD24 with arg >= NUM_BLOCKS: R1=0x40, no data phase. arg is a block address.
- Any other index: R1 = 0x04 | card_idle.
- Read (CMD17): R1=0x00, then RD_DELAY_BYTES x 0xFF, token 0xFE, BLOCK_BYTES data, 2 CRC bytes, then back to CMD_RX.
- Write (CMD24): R1=0x00, then WR_TOKEN. mosi bytes of 0xFF are skipped; 0xFE starts WR_DATA; any other byte aborts to CMD_RX.
- WR_DATA: BLOCK_BYTES go into a staging buffer, then 2 CRC bytes.
- Data response: 0x05 when accepted, with the buffer copied to mem[arg] at the same time. Then busy=1 and BUSY_BYTES x 0x00 are sent, then busy=0 and miso returns to 0xFF bytes.
- Commands are not decoded until busy ends.
- A read immediately after a write returns the new data.
- Byte counters wrap cleanly: a block index of NUM_BLOCKS-1 is legal.

Optional Feature:
SD_CRC_CHECK_EN.
- Defined: CRC7 of command bytes 0-4 is checked. A mismatch gives R1 = 0x08 | card_idle and the command is not executed. Read CRC is the real CRC16-CCITT of the data. A write CRC16 mismatch gives data response 0x0B and memory is unchanged.
- Undefined: all received CRC bytes are ignored, and the read CRC is sent as 0xFFFF.

Test Plan:
1. CMD0 (40 00 00 00 00 95) -> after 1x 0xFF, R1=0x01; cmd_index=0; cmd_strobe pulses once.
2. CMD8 arg 0x1AA, then CMD55+ACMD41 twice -> R7 = 01 00 00 01 AA; ACMD41 R1 = 0x01 then 0x00; card_idle falls; CMD58 returns 00 C0 FF 80 00.
3. After init, CMD17 arg 3 -> 00, FF FF, FE, bytes 0x30..0x3F, 2 CRC bytes; CMD17 arg 8 -> R1=0x40 with no token.
4. CMD24 arg 5 with token FE and data A5 repeated 16 times -> response 0x05; busy high for 3 bytes; a following CMD17 arg 5 returns 16x A5.
5. CMD24 with cs_n deasserted after 7 data bytes, then CMD17 of the same block -> original pattern returned; miso=1 while cs_n is high.
6. SD_CRC_CHECK_EN defined: CMD0 with CRC byte 0x00 -> R1=0x09. Write with a wrong CRC16 -> response 0x0B and memory unchanged.

Source files
------------

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card slave model: init handshake (CMD0/8/55/ACMD41/58), single-block
// read (CMD17) and write (CMD24) against a small block memory. SPI pins are
// oversampled in the clk domain. Define SD_CRC_CHECK_EN to check command CRC7 and
// write CRC16 and to send a real read CRC16; otherwise CRCs are ignored and sent as 0xFFFF.
module sd_spi_card_model #(
    parameter int unsigned BLOCK_BYTES    = 16,
    parameter int unsigned NUM_BLOCKS     = 8,
    parameter int unsigned NCR_BYTES      = 1,
    parameter int unsigned INIT_POLLS     = 2,
    parameter int unsigned RD_DELAY_BYTES = 2,
    parameter int unsigned BUSY_BYTES     = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cs_ni,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       card_idle_o,
    output logic       cmd_strobe_o,
    output logic [5:0] cmd_index_o,
    output logic       busy_o
);
    localparam int unsigned IdxW     = $clog2(BLOCK_BYTES);
    localparam int unsigned BlkW     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned MemDepth = 1 << (BlkW + IdxW);
    localparam logic [15:0] CntBlock = 16'(BLOCK_BYTES);
    localparam logic [15:0] CntNcr   = 16'(NCR_BYTES);
    localparam logic [15:0] CntRdPre = 16'(RD_DELAY_BYTES);
    localparam logic [15:0] CntBusy  = 16'(BUSY_BYTES);

    typedef enum logic [3:0] {
        StCmdRx, StNcr, StResp, StRdPre, StRdData, StRdCrc,
        StWrToken, StWrData, StWrCrc, StWrResp, StWrBusy
    } state_e;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

`ifdef SD_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    logic                 sclk_q, rise, fall, rx_done, miso_q;
    logic [2:0]           bit_q;
    logic [7:0]           rx_sr_q, rx_byte, tx_sr_q, tx_next_q, tx_next_d;
    state_e               state_q, state_d, after_q, after_d;
    logic [15:0]          cnt_q, cnt_d, crc_q, crc_d, crc_out;
    logic [37:0]          cmd_q, cmd_d;
    logic [39:0]          resp_q, resp_d;
    logic [2:0]           resp_len_q, resp_len_d;
    logic [BlkW-1:0]      blk_q, blk_d;
    logic                 idle_q, idle_d, app_q, app_d, strobe_q, strobe_d, busy_q, busy_d;
    logic [3:0]           poll_q, poll_d;
    logic [5:0]           index_q, index_d, cmd_idx;
    logic [31:0]          cmd_arg, extra;
    logic                 crc_ok, wr_ok, ill, perr, stage_we, commit;
    logic [(1<<BlkW)-1:0] written_q;
    logic [7:0]           stage_q [BLOCK_BYTES];
    logic [7:0]           mem_q [MemDepth];
    logic [IdxW-1:0]      rd_idx;
    logic [BlkW+IdxW-1:0] rd_addr;
    logic [7:0]           rd_data;
`ifdef SD_CRC_CHECK_EN
    logic [7:0]           wr_crc_q, wr_crc_d;
`endif

    assign rise    = sclk_i & ~sclk_q & ~cs_ni;
    assign fall    = ~sclk_i & sclk_q & ~cs_ni;
    assign rx_byte = {rx_sr_q[6:0], mosi_i};
    assign rx_done = rise && (bit_q == 3'd7);
    assign cmd_idx = cmd_q[37:32];
    assign cmd_arg = cmd_q[31:0];
    assign rd_idx  = (state_q == StRdData) ? cnt_q[IdxW-1:0] : '0;
    assign rd_addr = {blk_q, rd_idx};
    // Blocks never written read back the address pattern (b*BLOCK_BYTES+i) mod 256.
    assign rd_data = written_q[blk_q] ? mem_q[rd_addr] : 8'(rd_addr);
`ifdef SD_CRC_CHECK_EN
    assign crc_out = crc_q;
`else
    assign crc_out = 16'hFFFF;
`endif

    // Bit-level shifter: mosi in on rise, miso out on fall; a new tx byte loads after each byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            rx_sr_q <= '0;
            tx_sr_q <= 8'hFF;
            miso_q  <= 1'b1;
        end else begin
            sclk_q <= sclk_i;
            if (cs_ni) begin
                bit_q   <= '0;
                tx_sr_q <= 8'hFF;
                miso_q  <= 1'b1;
            end else begin
                if (rise) begin
                    rx_sr_q <= rx_byte;
                    bit_q   <= bit_q + 3'd1;
                end
                if (fall) begin
                    if (bit_q == 3'd0) begin
                        miso_q  <= tx_next_q[7];
                        tx_sr_q <= {tx_next_q[6:0], 1'b1};
                    end else begin
                        miso_q  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                    end
                end
            end
        end
    end

    // Byte-level protocol FSM: advances once per completed byte and picks the next tx byte.
    always_comb begin
        state_d    = state_q;
        after_d    = after_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        resp_d     = resp_q;
        resp_len_d = resp_len_q;
        blk_d      = blk_q;
        idle_d     = idle_q;
        app_d      = app_q;
        poll_d     = poll_q;
        strobe_d   = 1'b0;
        index_d    = index_q;
        busy_d     = busy_q;
        crc_d      = crc_q;
        tx_next_d  = tx_next_q;
        stage_we   = 1'b0;
        commit     = 1'b0;
        ill        = 1'b0;
        perr       = 1'b0;
        extra      = '0;
        crc_ok     = 1'b1;
        wr_ok      = 1'b1;
`ifdef SD_CRC_CHECK_EN
        wr_crc_d   = wr_crc_q;
        crc_ok     = (rx_byte[7:1] == crc7({2'b01, cmd_q}));
        wr_ok      = ({wr_crc_q, rx_byte} == crc_q);
`endif
        if (cs_ni) begin
            state_d   = StCmdRx;
            cnt_d     = '0;
            busy_d    = 1'b0;
            tx_next_d = 8'hFF;
        end else if (rx_done) begin
            tx_next_d = 8'hFF;
            unique case (state_q)
                StCmdRx: begin
                    if (cnt_q == 16'd5) begin
                        strobe_d   = 1'b1;
                        index_d    = cmd_idx;
                        app_d      = 1'b0;
                        after_d    = StCmdRx;
                        resp_len_d = 3'd1;
                        if (crc_ok) begin
                            unique case (cmd_idx)
                                6'd0: begin
                                    idle_d = 1'b1;
                                    poll_d = '0;
                                end
                                6'd8: begin
                                    resp_len_d = 3'd5;
                                    extra      = {20'h0, cmd_arg[11:0]};
                                end
                                6'd55: app_d = 1'b1;
                                6'd41: begin
                                    if (app_q) begin
                                        if (poll_q != 4'hF) poll_d = poll_q + 4'd1;
                                        if (({1'b0, poll_q} + 5'd1) >= 5'(INIT_POLLS)) idle_d = 1'b0;
                                    end else begin
                                        ill = 1'b1;
                                    end
                                end
                                6'd58: begin
                                    resp_len_d = 3'd5;
                                    extra      = idle_q ? 32'h00FF8000 : 32'hC0FF8000;
                                end
                                6'd17, 6'd24: begin
                                    if (idle_q) ill = 1'b1;
                                    else if (cmd_arg >= 32'(NUM_BLOCKS)) perr = 1'b1;
                                    else begin
                                        blk_d   = cmd_arg[BlkW-1:0];
                                        after_d = (cmd_idx == 6'd17) ? StRdPre : StWrToken;
                                    end
                                end
                                default: ill = 1'b1;
                            endcase
                        end
                        resp_d  = {1'b0, perr, 2'b00, ~crc_ok, ill, 1'b0, idle_d, extra};
                        state_d = StNcr;
                        cnt_d   = 16'd1;
                    end else if (cnt_q != 16'd0 || rx_byte[7:6] == 2'b01) begin
                        cmd_d = {cmd_q[29:0], rx_byte};
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StNcr, StResp: begin
                    if ((state_q == StNcr && cnt_q == CntNcr) ||
                        (state_q == StResp && cnt_q != {13'd0, resp_len_q})) begin
                        tx_next_d = resp_q[39:32];
                        resp_d    = {resp_q[31:0], 8'hFF};
                        cnt_d     = (state_q == StNcr) ? 16'd1 : cnt_q + 16'd1;
                        state_d   = StResp;
                    end else if (state_q == StNcr) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        state_d = after_q;
                        cnt_d   = (after_q == StRdPre) ? 16'd1 : 16'd0;
                        if (after_q == StRdPre && CntRdPre == 16'd0) tx_next_d = 8'hFE;
                    end
                end
                StRdPre: begin
                    if (cnt_q == CntRdPre + 16'd1) begin
                        state_d   = StRdData;
                        tx_next_d = rd_data;
                        crc_d     = crc16_byte(16'h0, rd_data);
                        cnt_d     = 16'd1;
                    end else begin
                        tx_next_d = (cnt_q == CntRdPre) ? 8'hFE : 8'hFF;
                        cnt_d     = cnt_q + 16'd1;
                    end
                end
                StRdData: begin
                    if (cnt_q == CntBlock) begin
                        state_d   = StRdCrc;
                        tx_next_d = crc_out[15:8];
                        cnt_d     = 16'd1;
                    end else begin
                        tx_next_d = rd_data;
                        crc_d     = crc16_byte(crc_q, rd_data);
                        cnt_d     = cnt_q + 16'd1;
                    end
                end
                StRdCrc: begin
                    if (cnt_q == 16'd2) begin
                        state_d = StCmdRx;
                        cnt_d   = '0;
                    end else begin
                        tx_next_d = crc_out[7:0];
                        cnt_d     = cnt_q + 16'd1;
                    end
                end
                StWrToken: begin
                    cnt_d = '0;
                    crc_d = '0;
                    if (rx_byte == 8'hFE) state_d = StWrData;
                    else if (rx_byte != 8'hFF) state_d = StCmdRx;
                end
                StWrData: begin
                    stage_we = 1'b1;
                    crc_d    = crc16_byte(crc_q, rx_byte);
                    if (cnt_q == CntBlock - 16'd1) begin
                        state_d = StWrCrc;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StWrCrc: begin
                    if (cnt_q == 16'd0) begin
`ifdef SD_CRC_CHECK_EN
                        wr_crc_d = rx_byte;
`endif
                        cnt_d = 16'd1;
                    end else begin
                        // Memory is only committed here, so an aborted write leaves it untouched.
                        commit    = wr_ok;
                        tx_next_d = wr_ok ? 8'h05 : 8'h0B;
                        state_d   = StWrResp;
                    end
                end
                StWrResp: begin
                    cnt_d = 16'd1;
                    if (CntBusy == 16'd0) begin
                        state_d = StCmdRx;
                        cnt_d   = '0;
                    end else begin
                        busy_d    = 1'b1;
                        tx_next_d = 8'h00;
                        state_d   = StWrBusy;
                    end
                end
                StWrBusy: begin
                    if (cnt_q == CntBusy) begin
                        busy_d  = 1'b0;
                        state_d = StCmdRx;
                        cnt_d   = '0;
                    end else begin
                        tx_next_d = 8'h00;
                        cnt_d     = cnt_q + 16'd1;
                    end
                end
                default: state_d = StCmdRx;
            endcase
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StCmdRx;
            after_q    <= StCmdRx;
            cnt_q      <= '0;
            cmd_q      <= '0;
            resp_q     <= '1;
            resp_len_q <= 3'd1;
            blk_q      <= '0;
            idle_q     <= 1'b1;
            app_q      <= 1'b0;
            poll_q     <= '0;
            strobe_q   <= 1'b0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            crc_q      <= '0;
            tx_next_q  <= 8'hFF;
            written_q  <= '0;
`ifdef SD_CRC_CHECK_EN
            wr_crc_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            after_q    <= after_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            resp_len_q <= resp_len_d;
            blk_q      <= blk_d;
            idle_q     <= idle_d;
            app_q      <= app_d;
            poll_q     <= poll_d;
            strobe_q   <= strobe_d;
            index_q    <= index_d;
            busy_q     <= busy_d;
            crc_q      <= crc_d;
            tx_next_q  <= tx_next_d;
            if (commit) written_q[blk_q] <= 1'b1;
`ifdef SD_CRC_CHECK_EN
            wr_crc_q   <= wr_crc_d;
`endif
        end
    end

    // Staging buffer and block memory (not reset).
    always_ff @(posedge clk_i) begin
        if (stage_we) stage_q[cnt_q[IdxW-1:0]] <= rx_byte;
        if (commit) begin
            for (int i = 0; i < BLOCK_BYTES; i++) mem_q[{blk_q, IdxW'(i)}] <= stage_q[i];
        end
    end

    assign miso_o       = miso_q;
    assign card_idle_o  = idle_q;
    assign cmd_strobe_o = strobe_q;
    assign cmd_index_o  = index_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_sd_spi_card_model.sv
// Directed bench for sd_spi_card_model: init handshake, read, write, aborted write
// and (with SD_CRC_CHECK_EN) CRC error handling. SPI master runs mode 0 at clk/8.
module tb_sd_spi_card_model;
    localparam int BB = 16;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, sclk, mosi;
    logic       miso, card_idle, cmd_strobe, busy;
    logic [5:0] cmd_index;

    int   n_checks = 0;
    int   n_pass = 0;
    int   strobe_cnt = 0;
    logic byte_busy = 1'b0;

    always #5 clk = ~clk;

    sd_spi_card_model #(
        .BLOCK_BYTES(16), .NUM_BLOCKS(8), .NCR_BYTES(1),
        .INIT_POLLS(2), .RD_DELAY_BYTES(2), .BUSY_BYTES(3)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .cs_ni(cs_n), .sclk_i(sclk), .mosi_i(mosi),
        .miso_o(miso), .card_idle_o(card_idle), .cmd_strobe_o(cmd_strobe),
        .cmd_index_o(cmd_index), .busy_o(busy)
    );

    // Count strobe pulses.
    always @(posedge clk) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk  = 1'b1;
            repeat (4) @(negedge clk);
            if (i == 4) byte_busy = busy;
            sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                            output logic [7:0] ncr, output logic [7:0] r1);
        logic [39:0] f;
        logic [7:0]  c, d;
        f = {2'b01, idx, arg};
        c = bad_crc ? 8'h00 : {crc7(f), 1'b1};
        for (int k = 4; k >= 0; k--) xfer(f[k*8 +: 8], d);
        xfer(c, d);
        xfer(8'hFF, ncr);
        xfer(8'hFF, r1);
    endtask

    task automatic read_block(input logic [31:0] blk, output logic [7:0] r1,
                              output logic [23:0] pre, output logic [127:0] data,
                              output logic [15:0] crc, output logic [15:0] crc_exp);
        logic [7:0] ncr, b;
        send_cmd(6'd17, blk, 1'b0, ncr, r1);
        pre = '0; data = '0; crc = '0; crc_exp = '0;
        for (int k = 0; k < 3; k++) begin
            xfer(8'hFF, b);
            pre = {pre[15:0], b};
        end
        for (int k = 0; k < BB; k++) begin
            xfer(8'hFF, b);
            data    = {data[119:0], b};
            crc_exp = crc16_upd(crc_exp, b);
        end
        xfer(8'hFF, b); crc[15:8] = b;
        xfer(8'hFF, b); crc[7:0]  = b;
`ifndef SD_CRC_CHECK_EN
        crc_exp = 16'hFFFF;
`endif
    endtask

    task automatic write_block(input logic [31:0] blk, input logic [7:0] val, input int n_data,
                               input bit bad_crc, output logic [7:0] r1,
                               output logic [39:0] resp, output logic [4:0] bz);
        logic [7:0]  ncr, b;
        logic [15:0] c;
        send_cmd(6'd24, blk, 1'b0, ncr, r1);
        resp = '0; bz = '0; c = '0;
        xfer(8'hFF, b);
        xfer(8'hFE, b);
        for (int k = 0; k < n_data; k++) begin
            xfer(val, b);
            c = crc16_upd(c, val);
        end
        if (n_data < BB) return;
        if (bad_crc) c = ~c;
        xfer(c[15:8], b);
        xfer(c[7:0], b);
        for (int k = 0; k < 5; k++) begin
            xfer(8'hFF, b);
            resp = {resp[31:0], b};
            bz   = {bz[3:0], byte_busy};
        end
    endtask

    initial begin
        logic [7:0]   r1, ncr, b;
        logic [39:0]  big;
        logic [23:0]  pre;
        logic [127:0] data;
        logic [15:0]  crc, crc_exp;
        logic [4:0]   bz;

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1'b1);
        check("rst_idle", card_idle, 1'b1);
        check("rst_strobe", cmd_strobe, 1'b0);
        check("rst_index", cmd_index, 6'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        xfer(8'hFF, b);

        // CMD0
        send_cmd(6'd0, 32'h0, 1'b0, ncr, r1);
        check("cmd0_ncr", ncr, 8'hFF);
        check("cmd0_r1", r1, 8'h01);
        check("cmd0_index", cmd_index, 6'd0);
        check("cmd0_strobes", strobe_cnt, 1);
`ifdef SD_CRC_CHECK_EN
        send_cmd(6'd0, 32'h0, 1'b1, ncr, r1);
        check("cmd0_badcrc_r1", r1, 8'h09);
`endif

        // CMD8 / ACMD41 init / CMD58
        send_cmd(6'd8, 32'h1AA, 1'b0, ncr, r1);
        big = {32'h0, r1};
        for (int k = 0; k < 4; k++) begin
            xfer(8'hFF, b);
            big = {big[31:0], b};
        end
        check("cmd8_r7", big, 40'h01000001AA);
        send_cmd(6'd55, 32'h0, 1'b0, ncr, r1);
        check("cmd55_r1", r1, 8'h01);
        send_cmd(6'd41, 32'h40000000, 1'b0, ncr, r1);
        check("acmd41_1_r1", r1, 8'h01);
        check("acmd41_1_idle", card_idle, 1'b1);
        send_cmd(6'd55, 32'h0, 1'b0, ncr, r1);
        send_cmd(6'd41, 32'h40000000, 1'b0, ncr, r1);
        check("acmd41_2_r1", r1, 8'h00);
        check("acmd41_2_idle", card_idle, 1'b0);
        send_cmd(6'd58, 32'h0, 1'b0, ncr, r1);
        big = {32'h0, r1};
        for (int k = 0; k < 4; k++) begin
            xfer(8'hFF, b);
            big = {big[31:0], b};
        end
        check("cmd58_r3", big, 40'h00C0FF8000);
        send_cmd(6'd41, 32'h0, 1'b0, ncr, r1);
        check("cmd41_noapp_r1", r1, 8'h04);
        check("cmd41_index", cmd_index, 6'd41);
        send_cmd(6'd13, 32'h0, 1'b0, ncr, r1);
        check("cmd13_r1", r1, 8'h04);

        // Reads
        read_block(32'd3, r1, pre, data, crc, crc_exp);
        check("rd3_r1", r1, 8'h00);
        check("rd3_pre", pre, 24'hFFFFFE);
        check("rd3_data", data, 128'h303132333435363738393A3B3C3D3E3F);
        check("rd3_crc", crc, crc_exp);
        read_block(32'd7, r1, pre, data, crc, crc_exp);
        check("rd7_data", data, 128'h707172737475767778797A7B7C7D7E7F);
        send_cmd(6'd17, 32'd8, 1'b0, ncr, r1);
        check("rd8_r1", r1, 8'h40);
        xfer(8'hFF, b);
        check("rd8_no_token", b, 8'hFF);

        // Write then read back
        write_block(32'd5, 8'hA5, BB, 1'b0, r1, big, bz);
        check("wr5_r1", r1, 8'h00);
        check("wr5_resp", big, 40'h05000000FF);
        check("wr5_busy", bz, 5'b01110);
        check("wr5_busy_after", busy, 1'b0);
        read_block(32'd5, r1, pre, data, crc, crc_exp);
        check("rd5_data", data, {16{8'hA5}});

        // Aborted write
        write_block(32'd6, 8'h11, 7, 1'b0, r1, big, bz);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("cs_high_miso", miso, 1'b1);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        read_block(32'd6, r1, pre, data, crc, crc_exp);
        check("rd6_r1", r1, 8'h00);
        check("rd6_data", data, 128'h606162636465666768696A6B6C6D6E6F);

`ifdef SD_CRC_CHECK_EN
        write_block(32'd2, 8'h3C, BB, 1'b1, r1, big, bz);
        check("wr2_badcrc_resp", big, 40'h0B000000FF);
        read_block(32'd2, r1, pre, data, crc, crc_exp);
        check("rd2_data", data, 128'h202122232425262728292A2B2C2D2E2F);
`endif

        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
